// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns the cpu's two-phase 8-bit pin bus into ROM/RAM requests.
// Address phase, then data phase, then an ACCESS state that waits for mem_ack,
// then a one-cycle cpu_ready pulse.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req, cpu_addr_data     phase strobe and phase select (0 addr, 1 data)
//   cpu_rom_ram, cpu_we        space (0 ROM, 1 RAM) and write flag
//   cpu_data_out, cpu_data_in  cpu bus in / read-data register out
//   cpu_ready                  one-cycle completion pulse
//   mem_addr, mem_wdata        latched address and write data
//   mem_rdata, mem_ack         memory read data and completion
//   mem_sel_rom, mem_sel_ram   space selects, high for all of ACCESS
//   mem_we                     RAM write enable
//   bus_err                    sticky timeout flag
// Optional: define BUS_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
// cycles without ack; otherwise ACCESS waits forever and bus_err stays 0.
module mem_bus_ctrl #(
    parameter int         TIMEOUT_CYCLES = 15,
    parameter logic [7:0] ERR_DATA       = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_addr_data,
    input  logic       cpu_rom_ram,
    input  logic       cpu_we,
    input  logic [7:0] cpu_data_out,
    output logic [7:0] cpu_data_in,
    output logic       cpu_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       mem_sel_rom,
    output logic       mem_sel_ram,
    output logic       mem_we,
    input  logic       mem_ack,
    output logic       bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_next;

    logic space;
    logic we;
    logic addr_phase;
    logic data_phase;
    logic timeout;

    assign addr_phase = cpu_req && !cpu_addr_data;
    assign data_phase = cpu_req && cpu_addr_data;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Abort on the edge where the count of ack-less ACCESS cycles
    // reaches TIMEOUT_CYCLES.
    assign timeout = (wait_cnt >= 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 8'h00;
            bus_err  <= 1'b0;
        end else begin
            if (state == ADDR && data_phase) begin
                wait_cnt <= 8'h00;
            end else if (state == ACCESS && !mem_ack) begin
                if (timeout) begin
                    bus_err <= 1'b1;
                end else if (wait_cnt != 8'hFF) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{TIMEOUT_CYCLES, ERR_DATA};
    assign timeout    = 1'b0;
    assign bus_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            space       <= 1'b0;
            we          <= 1'b0;
            mem_addr    <= 8'h00;
            mem_wdata   <= 8'h00;
            cpu_data_in <= 8'h00;
        end else begin
            state <= state_next;
            if ((state == IDLE || state == ADDR) && addr_phase) begin
                mem_addr <= cpu_data_out;
                space    <= cpu_rom_ram;
            end
            if (state == ADDR && data_phase) begin
                we        <= cpu_we;
                mem_wdata <= cpu_data_out;
            end
            if (state == ACCESS && !we) begin
                if (mem_ack) begin
                    cpu_data_in <= mem_rdata;
                end else if (timeout) begin
`ifdef BUS_TIMEOUT_EN
                    cpu_data_in <= ERR_DATA;
`endif
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        mem_sel_rom = 1'b0;
        mem_sel_ram = 1'b0;
        mem_we      = 1'b0;
        cpu_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                if (addr_phase) state_next = ADDR;
            end
            ADDR: begin
                // ROM writes are dropped without touching memory.
                if (data_phase) begin
                    if (!space && cpu_we) state_next = RESP;
                    else                  state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_sel_rom = !space;
                mem_sel_ram = space;
                mem_we      = space & we;
                if (mem_ack || timeout) state_next = RESP;
            end
            RESP: begin
                cpu_ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
